// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;
    localparam int NUM_REQ      = 8;
    localparam int IDX_W        = 3;
    localparam int HOLD_MAX_DEF = 8;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arbiter8_decoder.sv
// Binary-to-one-hot decoder used on the one-hot select path.
module decoder #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]        N,
    output logic [(1<<IN_W)-1:0]   output_vector
);
    genvar gi;
    generate
        for (gi = 0; gi < (1 << IN_W); gi++) begin : g_dec
            assign output_vector[gi] = (N == IN_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters: holds a grant until release or hold
// timeout, and presents the owner both as an index and as a one-hot vector.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic [CNT_W-1:0]   hold_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic             TIMEOUT_EN = (HOLD_MAX != 0);

    state_t             state_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   gnt_idx_reg;
    logic               gnt_valid_reg;
    logic [CNT_W-1:0]   hold_cnt_reg;
    logic [NUM_REQ-1:0] owner_onehot;
    logic [NUM_REQ-1:0] others;
    logic               timeout;

    // First set bit of r after position p, wrapping; p itself is checked last.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p,
                                                  input logic [NUM_REQ-1:0] r);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] cand;
        logic             found;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = p + IDX_W'(k);
            if (!found && r[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    decoder #(.IN_W(IDX_W)) u_decoder (
        .N             (gnt_idx_reg),
        .output_vector (owner_onehot)
    );

    assign others  = req & ~owner_onehot;
    assign timeout = TIMEOUT_EN && (hold_cnt_reg == HOLD_LAST) && (others != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= IDX_W'(NUM_REQ - 1);
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            hold_cnt_reg  <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (req != '0) begin
                state_reg     <= ST_GRANT;
                gnt_idx_reg   <= next_idx(ptr_reg, req);
                gnt_valid_reg <= 1'b1;
                hold_cnt_reg  <= '0;
            end
        end else begin
            if (!req[gnt_idx_reg]) begin
                // Release wins over a coincident timeout; both give the same result.
                ptr_reg      <= gnt_idx_reg;
                hold_cnt_reg <= '0;
                if (req != '0) begin
                    gnt_idx_reg <= next_idx(gnt_idx_reg, req);
                end else begin
                    state_reg     <= ST_IDLE;
                    gnt_valid_reg <= 1'b0;
                end
            end else if (timeout) begin
                ptr_reg      <= gnt_idx_reg;
                gnt_idx_reg  <= next_idx(gnt_idx_reg, others);
                hold_cnt_reg <= '0;
            end else if (hold_cnt_reg != CNT_MAX) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

    assign gnt       = owner_onehot & {NUM_REQ{gnt_valid_reg}};
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;
    assign hold_cnt  = hold_cnt_reg;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a rule-level model predicts each cycle's
// grant and a negedge monitor compares it against the DUT.
module tb_rr_arbiter8;
    localparam int HM = 8;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic [CW-1:0] hold_cnt;

    rr_arbiter8 #(.HOLD_MAX(HM), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] req;
        bit         valid;
        int         owner;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state in plain integers.
    bit m_valid;
    int m_owner;
    int m_cnt;
    int m_ptr;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int mnext(input int p, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_owner = 0;
        m_cnt   = 0;
        m_ptr   = 7;
    endtask

    task automatic model_step(input logic [7:0] r);
        logic [7:0] oth;
        if (!m_valid) begin
            if (r != 0) begin
                m_owner = mnext(m_ptr, r);
                m_valid = 1'b1;
                m_cnt   = 0;
            end
        end else if (!r[m_owner]) begin
            m_ptr = m_owner;
            m_cnt = 0;
            if (r != 0) m_owner = mnext(m_owner, r);
            else m_valid = 1'b0;
        end else begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (HM != 0 && m_cnt == HM - 1 && oth != 0) begin
                m_ptr   = m_owner;
                m_owner = mnext(m_owner, oth);
                m_cnt   = 0;
            end else if (m_cnt < SAT) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // Drive req for one cycle and queue the expected post-edge outputs.
    task automatic step(input logic [7:0] r);
        exp_t e;
        req = r;
        model_step(r);
        e.cyc   = cyc + 1;
        e.req   = r;
        e.valid = m_valid;
        e.owner = m_owner;
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        exp_t e;
        logic [7:0] eg;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            eg = e.valid ? (8'h01 << e.owner) : 8'h00;
            $display("cyc %0d req %02h gnt %02h idx %0d valid %0d cnt %0d", cyc, e.req, gnt,
                     gnt_idx, gnt_valid, hold_cnt);
            chk("gnt", int'(gnt), int'(eg));
            chk("gnt_valid", int'(gnt_valid), int'(e.valid));
            if (e.valid) begin
                chk("gnt_idx", int'(gnt_idx), e.owner);
                chk("hold_cnt", int'(hold_cnt), e.cnt);
            end
        end
    end

    logic [7:0] r;

    initial begin
        rst = 1'b1;
        req = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_valid", int'(gnt_valid), 0);
        chk("reset_idx", int'(gnt_idx), 0);
        chk("reset_cnt", int'(hold_cnt), 0);
        rst = 1'b0;

        // Single request: one-cycle latency to grant on 2.
        step(8'h04);
        step(8'h04);
        step(8'h00);
        step(8'h00);

        // All requesting, each owner releases after two grant cycles.
        for (int i = 0; i < 24; i++) begin
            r = 8'hFF;
            if (m_valid && m_cnt == 1) r[m_owner] = 1'b0;
            step(r);
        end
        step(8'h00);

        // Two contenders held: timeout alternates 0 and 7.
        for (int i = 0; i < 40; i++) step(8'h81);
        step(8'h00);

        // Lone requester: counter saturates, no switch, then release.
        for (int i = 0; i < 20; i++) step(8'h02);
        step(8'h00);
        step(8'h00);

        // Asynchronous reset mid-grant on owner 5 at hold_cnt 3.
        for (int i = 0; i < 4; i++) step(8'h20);
        #3;
        rst = 1'b1;
        sb.delete();
        model_reset();
        #1;
        chk("async_gnt", int'(gnt), 0);
        chk("async_valid", int'(gnt_valid), 0);
        chk("async_idx", int'(gnt_idx), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(8'h21);
        step(8'h21);
        step(8'h00);

        // Owner 3 releases as request 4 rises while 6 waits: 4 wins.
        step(8'h08);
        step(8'h48);
        step(8'h48);
        step(8'h50);
        step(8'h50);
        step(8'h00);

        // Randomized traffic with sticky request patterns and owner releases.
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) r = 8'($urandom);
            if (m_valid && $urandom_range(0, 9) == 0) r[m_owner] = 1'b0;
            step(r);
        end
        step(8'h00);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
